// File: rtl/serial_frame_scheduler.sv
// Round-robin scheduler that time-shares one serial "111" detector among N_REQ requesters.
// Each granted frame is re-aligned with a detector reset, shifted LSB-first and reported with its id.
module serial_frame_scheduler #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [N_REQ-1:0]     Req,
  input  logic [3*N_REQ-1:0]   Frame_Data,
  output logic [N_REQ-1:0]     Grant,
  output logic                 Busy,
  output logic                 Det_Data_In,
  output logic                 Det_Reset_n,
  input  logic                 Det_Data_Out,
  output logic                 Done_Valid,
  output logic [ID_W-1:0]      Done_Id,
  output logic                 Done_Match
);

  typedef enum logic [2:0] {IDLE, SYNC, SHIFT0, SHIFT1, SHIFT2, REPORT} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [2:0]        frame_q, frame_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              det_in_q, det_in_d;
  logic              det_rst_n_q, det_rst_n_d;
  logic              done_valid_q, done_valid_d;
  logic [ID_W-1:0]   done_id_q, done_id_d;
  logic              done_match_q, done_match_d;

  logic [2:0]        frame_w [N_REQ];
  logic              found;
  logic [ID_W-1:0]   win;

  for (genvar g = 0; g < N_REQ; g++) begin : g_frame
    assign frame_w[g] = Frame_Data[3*g +: 3];
  end

  // First pending request strictly after the last winner, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && Req[(int'(ptr_q) + k) % N_REQ]) begin
        found = 1'b1;
        win   = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    id_d         = id_q;
    frame_d      = frame_q;
    grant_d      = '0;
    det_in_d     = det_in_q;
    det_rst_n_d  = det_rst_n_q;
    done_valid_d = 1'b0;
    done_id_d    = done_id_q;
    done_match_d = done_match_q;

    case (state_q)
      IDLE, REPORT: begin
        det_rst_n_d = 1'b0;
        state_d     = IDLE;
        if (found) begin
          ptr_d        = win;
          id_d         = win;
          frame_d      = frame_w[win];
          grant_d[win] = 1'b1;
          state_d      = SYNC;
        end
      end
      SYNC: begin
        det_rst_n_d = 1'b1;
        det_in_d    = frame_q[0];
        state_d     = SHIFT0;
      end
      SHIFT0: begin
        det_in_d = frame_q[1];
        state_d  = SHIFT1;
      end
      SHIFT1: begin
        det_in_d = frame_q[2];
        state_d  = SHIFT2;
      end
      SHIFT2: begin
        // Detector has consumed bits 0 and 1; its Mealy output now covers bit 2.
        done_match_d = Det_Data_Out;
        done_valid_d = 1'b1;
        done_id_d    = id_q;
        det_in_d     = 1'b0;
        state_d      = REPORT;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      ptr_q        <= ID_W'(N_REQ - 1);
      id_q         <= '0;
      frame_q      <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      det_in_q     <= 1'b0;
      det_rst_n_q  <= 1'b0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_match_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      id_q         <= id_d;
      frame_q      <= frame_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      det_in_q     <= det_in_d;
      det_rst_n_q  <= det_rst_n_d;
      done_valid_q <= done_valid_d;
      done_id_q    <= done_id_d;
      done_match_q <= done_match_d;
    end
  end

  assign Grant       = grant_q;
  assign Busy        = busy_q;
  assign Det_Data_In = det_in_q;
  assign Det_Reset_n = det_rst_n_q;
  assign Done_Valid  = done_valid_q;
  assign Done_Id     = done_id_q;
  assign Done_Match  = done_match_q;

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Scoreboard bench for serial_frame_scheduler with a behavioural "111" Mealy detector attached.
module tb_serial_frame_scheduler;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                Clock = 1'b0;
  logic                Reset;
  logic [N_REQ-1:0]    Req;
  logic [3*N_REQ-1:0]  Frame_Data;
  logic [N_REQ-1:0]    Grant;
  logic                Busy, Det_Data_In, Det_Reset_n, Det_Data_Out;
  logic                Done_Valid, Done_Match;
  logic [ID_W-1:0]     Done_Id;

  serial_frame_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .Clock(Clock), .Reset(Reset), .Req(Req), .Frame_Data(Frame_Data),
    .Grant(Grant), .Busy(Busy), .Det_Data_In(Det_Data_In), .Det_Reset_n(Det_Reset_n),
    .Det_Data_Out(Det_Data_Out), .Done_Valid(Done_Valid), .Done_Id(Done_Id),
    .Done_Match(Done_Match)
  );

  always #5 Clock = ~Clock;

  // Shared detector: counts consecutive ones, output is Mealy on the third.
  logic [1:0] det_st;
  always @(posedge Clock or negedge Det_Reset_n) begin
    if (!Det_Reset_n)     det_st <= 2'd0;
    else if (Det_Data_In) det_st <= (det_st == 2'd2) ? 2'd2 : det_st + 2'd1;
    else                  det_st <= 2'd0;
  end
  assign Det_Data_Out = (det_st == 2'd2) && Det_Data_In;

  typedef struct packed { logic [ID_W-1:0] id; logic m; } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    if (!Reset && Done_Valid) begin
      if (q.size() == 0) chk("unexpected_done", 32'(Done_Valid), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("done_id", 32'(Done_Id), 32'(e.id));
        chk("done_match", 32'(Done_Match), 32'(e.m));
      end
    end
  end

  task automatic wait_grant(output logic [N_REQ-1:0] g);
    int t = 0;
    do begin
      @(negedge Clock);
      t++;
    end while (Grant == '0 && t < 20);
    chk("grant_seen", 32'(Grant != '0), 32'd1);
    g = Grant;
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_det_rst_n", 32'(Det_Reset_n), 32'd0);
    chk("rst_done_valid", 32'(Done_Valid), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
  endtask

  task automatic run_single(input int id, input logic [2:0] frame, input logic exp_m, input logic corrupt);
    logic [N_REQ-1:0] g;
    Frame_Data[3*id +: 3] = frame;
    Req = N_REQ'(1 << id);
    wait_grant(g);
    chk("grant_single", 32'(g), 32'(1 << id));
    q.push_back(exp_t'{ID_W'(id), exp_m});
    Req = '0;
    if (corrupt) Frame_Data[3*id +: 3] = ~frame;
    chk("sync_det_rst_n", 32'(Det_Reset_n), 32'd0);
    for (int b = 0; b < 3; b++) begin
      @(negedge Clock);
      chk("det_data_in", 32'(Det_Data_In), 32'(frame[b]));
      chk("shift_det_rst_n", 32'(Det_Reset_n), 32'd1);
    end
    @(negedge Clock);
    chk("done_latency", 32'(Done_Valid), 32'd1);
    chk("report_det_in", 32'(Det_Data_In), 32'd0);
    @(negedge Clock);
    chk("done_pulse", 32'(Done_Valid), 32'd0);
    chk("idle_busy", 32'(Busy), 32'd0);
  endtask

  // ids: 2 bits per expected winner, entry 0 in the low bits.
  task automatic run_rr(input logic [N_REQ-1:0] req, input int n, input logic [15:0] ids);
    logic [N_REQ-1:0] g;
    logic [ID_W-1:0]  id;
    Req = req;
    wait_grant(g);
    id = ids[1:0];
    chk("grant_rr_first", 32'(g), 32'(1 << id));
    q.push_back(exp_t'{id, &Frame_Data[3*id +: 3]});
    for (int k = 1; k < n; k++) begin
      repeat (4) begin
        @(negedge Clock);
        chk("rr_busy", 32'(Busy), 32'd1);
        chk("rr_no_grant", 32'(Grant), 32'd0);
      end
      @(negedge Clock);
      id = ids[2*k +: 2];
      chk("grant_rr", 32'(Grant), 32'(1 << id));
      chk("rr_busy", 32'(Busy), 32'd1);
      q.push_back(exp_t'{id, &Frame_Data[3*id +: 3]});
    end
    Req = '0;
    repeat (6) @(negedge Clock);
  endtask

  initial begin
    logic [N_REQ-1:0] g;
    Reset = 1'b1; Req = '0; Frame_Data = '0;
    repeat (2) @(negedge Clock);
    chk("reset_grant", 32'(Grant), 32'd0);
    chk("reset_busy", 32'(Busy), 32'd0);
    chk("reset_det_in", 32'(Det_Data_In), 32'd0);
    chk("reset_det_rst_n", 32'(Det_Reset_n), 32'd0);
    chk("reset_done", 32'({Done_Valid, Done_Id, Done_Match}), 32'd0);
    Reset = 1'b0;
    @(negedge Clock);

    run_single(0, 3'b111, 1'b1, 1'b0);
    run_single(0, 3'b101, 1'b0, 1'b0);
    run_single(0, 3'b011, 1'b0, 1'b0);
    run_single(0, 3'b110, 1'b0, 1'b0);
    run_single(0, 3'b000, 1'b0, 1'b0);
    chk("done_hold_id", 32'(Done_Id), 32'd0);
    run_single(0, 3'b111, 1'b1, 1'b1);
    run_single(0, 3'b000, 1'b0, 1'b1);

    do_reset();
    Frame_Data = 12'hFFF;
    run_rr(4'b1111, 5, 16'b00_11_10_01_00);

    do_reset();
    Frame_Data = 12'b111_010_111_111;
    run_rr(4'b0101, 4, 16'b10_00_10_00);

    Frame_Data[2:0] = 3'b111;
    Req = 4'b0001;
    wait_grant(g);
    chk("grant_pre_abort", 32'(g), 32'd1);
    Req = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    #1;
    chk("abort_det_rst_n", 32'(Det_Reset_n), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done_Valid), 32'd0);
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    repeat (3) @(negedge Clock);
    chk("abort_no_regrant", 32'(Grant), 32'd0);
    run_single(1, 3'b111, 1'b1, 1'b0);

    repeat (4) @(negedge Clock);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d failures", n_chk, n_fail);
    $fatal(1);
  end
endmodule
